// File: rtl/fifo_stream_pkg.sv
// Shared constants and sizing helpers for the FIFO stream reader and its
// output buffer.
package fifo_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_BUF_DEPTH  = 3;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Circular output buffer with push/pop/flush; the head entry is presented
// combinationally so a stalled word stays stable on the output.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  // Pointers wrap explicitly so any depth works, not only powers of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the async FIFO read port into a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a credit-managed output buffer.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic [DATA_WIDTH-1:0]         fifo_q_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_deq_o,
  input  logic                          flush_i,
  output logic [DATA_WIDTH-1:0]         stream_data_o,
  output logic                          stream_valid_o,
  input  logic                          stream_ready_i,
  output logic [cnt_w(BUF_DEPTH)-1:0]   buf_count_o
);

  localparam int CW = cnt_w(BUF_DEPTH);

  logic          inflight;
  logic          push;
  logic          pop;
  logic [CW:0]   credits_used;

  // Credits count buffered words plus the one still on its way from the FIFO;
  // only registered state feeds the dequeue so ready never reaches fifo_deq_o.
  always_comb begin
    credits_used = {1'b0, buf_count_o} + {{CW{1'b0}}, inflight};
    fifo_deq_o   = !fifo_empty_i && !flush_i && !reset_i &&
                   (credits_used < (CW+1)'(BUF_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_deq_o;
    end
  end

  assign push           = inflight && !flush_i;
  assign stream_valid_o = (buf_count_o != '0);
  assign pop            = stream_valid_o && stream_ready_i && !flush_i;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset_i),
    .flush     (flush_i),
    .push      (push),
    .push_data (fifo_q_i),
    .pop       (pop),
    .head_data (stream_data_o),
    .count     (buf_count_o)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: a queue-based FIFO and scoreboard
// predict dequeues, occupancy and the delivered word order for two buffer depths.
module tb_fifo_stream_reader;
  import fifo_stream_pkg::*;

  localparam int DW     = 32;
  localparam int DEPTH  = 3;
  localparam int DEPTH2 = 2;
  localparam int CW     = cnt_w(DEPTH);
  localparam int CW2    = cnt_w(DEPTH2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          flush;
  logic          stream_ready;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic          deq;
  logic          valid;
  logic [DW-1:0] data;
  logic [CW-1:0] count;

  logic [DW-1:0]  fifo_q2;
  logic           fifo_empty2;
  logic           deq2;
  logic           valid2;
  logic [DW-1:0]  data2;
  logic [CW2-1:0] count2;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_i        (reset),
    .fifo_q_i       (fifo_q),
    .fifo_empty_i   (fifo_empty),
    .fifo_deq_o     (deq),
    .flush_i        (flush),
    .stream_data_o  (data),
    .stream_valid_o (valid),
    .stream_ready_i (stream_ready),
    .buf_count_o    (count)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH2)) dut2 (
    .clk            (clk),
    .reset_i        (reset),
    .fifo_q_i       (fifo_q2),
    .fifo_empty_i   (fifo_empty2),
    .fifo_deq_o     (deq2),
    .flush_i        (1'b0),
    .stream_data_o  (data2),
    .stream_valid_o (valid2),
    .stream_ready_i (1'b1),
    .buf_count_o    (count2)
  );

  int tests_run;
  int tests_failed;
  int cyc;
  int peak;
  int next2;
  int delivered2;
  int active2;
  bit pend;
  bit pend2;
  bit after_reset;
  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] src2[$];
  logic [DW-1:0] exp2[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  task automatic loadWords(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      src.push_back(base + DW'(i));
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic applyStimulus(input bit rdy, input bit fl, input bit rs);
    int occ, buffered, occ2, buf2;
    bit want_deq, take, want_deq2, take2;
    logic [DW-1:0] w, w2;
    stream_ready = rdy;
    flush        = fl;
    reset        = rs;
    while (src2.size() < 4) begin
      src2.push_back(DW'(next2));
      next2++;
    end
    #1;
    // Words popped but not yet delivered equal buffer count plus the in-flight word.
    occ      = exp_q.size();
    buffered = occ - (pend ? 1 : 0);
    want_deq = !fifo_empty && !fl && !rs && (occ < DEPTH);
    checkOutput("deq", 64'(deq), 64'(want_deq));
    checkOutput("deq_while_empty", 64'(deq & fifo_empty), 64'(0));
    checkOutput("count", 64'(count), 64'(buffered));
    checkOutput("count_bound", 64'(count <= CW'(DEPTH)), 64'(1));
    checkOutput("valid", 64'(valid), 64'(buffered != 0));
    if (buffered != 0) checkOutput("head_data", 64'(data), 64'(exp_q[0]));
    if (after_reset) checkOutput("data_after_reset", 64'(data), 64'(0));
    take = (buffered != 0) && rdy && !fl && !rs;
    if (!rs && int'(count) > peak) peak = int'(count);

    occ2      = exp2.size();
    buf2      = occ2 - (pend2 ? 1 : 0);
    want_deq2 = !fifo_empty2 && !rs && (occ2 < DEPTH2);
    checkOutput("d2_deq", 64'(deq2), 64'(want_deq2));
    checkOutput("d2_count", 64'(count2), 64'(buf2));
    checkOutput("d2_valid", 64'(valid2), 64'(buf2 != 0));
    if (buf2 != 0) checkOutput("d2_head_data", 64'(data2), 64'(exp2[0]));
    take2 = (buf2 != 0) && !rs;
    if (!rs) active2++;

    w  = $urandom();
    w2 = $urandom();
    if (rs) begin
      exp_q.delete(); src.delete(); pend = 0;
      exp2.delete();  src2.delete(); pend2 = 0;
    end else begin
      if (fl) begin
        exp_q.delete();
        pend = 0;
      end else begin
        if (take) void'(exp_q.pop_front());
        if (want_deq && src.size() != 0) begin
          w = src.pop_front();
          exp_q.push_back(w);
        end
        pend = want_deq;
      end
      if (take2) begin
        void'(exp2.pop_front());
        delivered2++;
      end
      if (want_deq2 && src2.size() != 0) begin
        w2 = src2.pop_front();
        exp2.push_back(w2);
      end
      pend2 = want_deq2;
    end

    @(posedge clk);
    #1;
    fifo_q      = w;
    fifo_empty  = (src.size() == 0);
    fifo_q2     = w2;
    fifo_empty2 = (src2.size() == 0);
    after_reset = rs;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit reached;
    tests_run = 0; tests_failed = 0; cyc = 0; peak = 0;
    next2 = 0; delivered2 = 0; active2 = 0;
    pend = 0; pend2 = 0; after_reset = 0;
    reset = 1'b1; flush = 1'b0; stream_ready = 1'b0;
    fifo_q = '0; fifo_empty = 1'b1; fifo_q2 = '0; fifo_empty2 = 1'b1;

    repeat (2) @(posedge clk);
    src.push_back(32'h11);
    src.push_back(32'h22);
    src.push_back(32'h33);
    while (src2.size() < 4) begin
      src2.push_back(DW'(next2));
      next2++;
    end
    @(posedge clk);
    #1;
    fifo_empty  = (src.size() == 0);
    fifo_empty2 = (src2.size() == 0);
    after_reset = 1;
    @(negedge clk);

    // Preloaded FIFO, continuous ready
    repeat (8) applyStimulus(1, 0, 0);

    // Stalled consumer fills the buffer to its credit limit
    peak = 0;
    loadWords(8, 32'h100);
    repeat (10) applyStimulus(0, 0, 0);
    checkOutput("peak_count", 64'(peak), 64'(DEPTH));
    repeat (16) applyStimulus(1, 0, 0);

    // Alternating ready
    loadWords(16, 32'h0);
    for (int i = 0; i < 40; i++) applyStimulus(i % 2 == 0, 0, 0);

    // Flush with two buffered words and one in flight
    loadWords(6, 32'h400);
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (exp_q.size() == 3 && pend) reached = 1;
      else applyStimulus(0, 0, 0);
    end
    checkOutput("flush_setup_timeout", 64'(reached), 64'(1));
    checkOutput("pre_flush_count", 64'(count), 64'(2));
    applyStimulus(1, 1, 0);
    repeat (20) applyStimulus(1, 0, 0);

    // Reset in the middle of a transfer
    loadWords(10, 32'h500);
    repeat (5) applyStimulus(1, 0, 0);
    repeat (2) applyStimulus(1, 0, 1);
    repeat (3) applyStimulus(1, 0, 0);
    loadWords(5, 32'h580);
    repeat (12) applyStimulus(1, 0, 0);

    // Random traffic, ready and occasional flush
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) loadWords($urandom_range(1, 3), $urandom());
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 0);
    end
    repeat (20) applyStimulus(1, 0, 0);

    checkOutput("d2_rate", 64'((delivered2 * 2 + 12) >= active2), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
